imem_port_arbiter: RTL and testbench

// - Sequences and shares the single-port, 1-cycle-latency synchronous instruction memory between the IF stage (fetch) and the program loader/debug port (load).
// - Issues at most one access at a time; returns the read data through valid/ready response channels.
// - Drives the memory hold input, so returned data stays stable while a response is back-pressured.
// - Sits between the IF stage / loader and the instruction memory instance.

---
 rtl/imem_arb_pkg.sv | 10 +
 rtl/arb_prio_sel.sv | 24 ++
 rtl/imem_port_arbiter.sv | 84 ++++++++
 tb/tb_imem_port_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: arbiter FSM encodings and the instruction memory range check.
package imem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_L} arb_state_e;
    localparam logic [1:0] ARB_IDLE   = IDLE;
    localparam logic [1:0] ARB_BUSY_F = BUSY_F;
    localparam logic [1:0] ARB_BUSY_L = BUSY_L;
    function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] mem_bytes);
        return addr <= mem_bytes - 64'd4;
    endfunction
endpackage

// File: rtl/arb_prio_sel.sv
// arb_prio_sel: fetch/load grant select; fixed load-first, or round-robin when IMEM_ARB_RR_EN is defined.
module arb_prio_sel (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_f,
    input  logic req_l,
    output logic gnt_f,
    output logic gnt_l
);
`ifdef IMEM_ARB_RR_EN
    logic prio_l;
    // Priority passes to the loser only when both sides contended.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) prio_l <= 1'b1;
        else if (en && req_f && req_l) prio_l <= ~prio_l;
    assign gnt_l = en && req_l && (!req_f || prio_l);
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign gnt_l = en && req_l;
`endif
    assign gnt_f = en && req_f && !gnt_l;
endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the 1-cycle single-port imem between fetch and loader.
// IMEM_ARB_RR_EN selects round-robin instead of fixed load-over-fetch priority.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 131072
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    input  logic              f_flush,
    output logic              f_rsp_valid,
    output logic [DATA_W-1:0] f_rsp_data,
    output logic              f_rsp_err,
    input  logic              f_rsp_ready,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rsp_valid,
    output logic [DATA_W-1:0] l_rsp_data,
    input  logic              l_rsp_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_stall,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic [1:0]        state;
    logic              err_q;
    logic              zero_q;
    logic [ADDR_W-1:0] addr_q;
    logic              f_ok;
    logic              l_ok;
    logic              free;

    assign f_ok = addr_ok(64'(f_addr), 64'(MEM_BYTES)) && f_addr[1:0] == 2'b00;
    assign l_ok = addr_ok(64'(l_addr), 64'(MEM_BYTES));

    assign f_rsp_valid = state == ARB_BUSY_F;
    assign l_rsp_valid = state == ARB_BUSY_L;
    assign f_rsp_err   = f_rsp_valid && err_q;
    assign f_rsp_data  = (f_rsp_valid && !err_q) ? mem_rdata : '0;
    assign l_rsp_data  = (l_rsp_valid && !zero_q) ? mem_rdata : '0;

    // A flushed fetch frees the port in the same cycle so the loader can take it.
    assign free = state == ARB_IDLE
               || (f_rsp_valid && (f_rsp_ready || f_flush))
               || (l_rsp_valid && l_rsp_ready);

    arb_prio_sel u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (free),
        .req_f (f_req && !f_flush),
        .req_l (l_req),
        .gnt_f (f_gnt),
        .gnt_l (l_gnt)
    );

    // Holding the address and stalling keeps mem_rdata frozen under back-pressure.
    assign mem_addr  = l_gnt ? l_addr : f_gnt ? f_addr : addr_q;
    assign mem_we    = l_gnt && l_we && l_ok;
    assign mem_wdata = l_gnt ? l_wdata : '0;
    assign mem_stall = !((l_gnt && l_ok) || (f_gnt && f_ok));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= ARB_IDLE;
            err_q  <= 1'b0;
            zero_q <= 1'b0;
            addr_q <= '0;
        end else begin
            state  <= l_gnt ? ARB_BUSY_L : f_gnt ? ARB_BUSY_F : free ? ARB_IDLE : state;
            err_q  <= f_gnt ? !f_ok : err_q;
            zero_q <= l_gnt ? (l_we || !l_ok) : zero_q;
            addr_q <= mem_addr;
        end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed + random stimulus against a transaction-level model.
module tb_imem_port_arbiter;
    localparam int MEM_BYTES = 131072;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0, f_flush = 1'b0, f_rsp_ready = 1'b0;
    logic [31:0] f_addr = '0;
    logic        l_req = 1'b0, l_we = 1'b0, l_rsp_ready = 1'b0;
    logic [31:0] l_addr = '0, l_wdata = '0;
    logic        f_gnt, f_rsp_valid, f_rsp_err, l_gnt, l_rsp_valid, mem_we, mem_stall;
    logic [31:0] f_rsp_data, l_rsp_data, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem    [0:32767];
    logic [31:0] shadow [0:32767];

    int          checks = 0;
    int          errors = 0;
    bit          pend = 0, pend_f = 0, pend_err = 0, ptr_l = 1;
    logic [31:0] pend_data = '0;

    always #5 clk = ~clk;

    imem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_flush(f_flush),
        .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
        .f_rsp_ready(f_rsp_ready),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
        .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data), .l_rsp_ready(l_rsp_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata)
    );

    // Environment memory: 1-cycle read, holds its output while stalled.
    always @(posedge clk)
        if (!mem_stall) begin
            if (mem_we) mem[mem_addr[16:2]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[16:2]];
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        {f_req, f_flush, f_rsp_ready, l_req, l_we, l_rsp_ready} = '0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
        rst_n = 1'b0;
        #1;
        check("rst f_gnt", 32'(f_gnt), 0);
        check("rst l_gnt", 32'(l_gnt), 0);
        check("rst f_rsp_valid", 32'(f_rsp_valid), 0);
        check("rst l_rsp_valid", 32'(l_rsp_valid), 0);
        check("rst f_rsp_err", 32'(f_rsp_err), 0);
        check("rst f_rsp_data", f_rsp_data, 0);
        check("rst l_rsp_data", l_rsp_data, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_we", 32'(mem_we), 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst mem_stall", 32'(mem_stall), 1);
        pend = 0;
        ptr_l = 1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive, check against the model, then advance the model past the edge.
    task automatic step(input bit fr, input logic [31:0] fa, input bit fl, input bit frdy,
                        input bit lr, input bit lw, input logic [31:0] la, input logic [31:0] ld,
                        input bit lrdy);
        bit free, fe, wl, wf, err, ok;
        @(negedge clk);
        f_req = fr; f_addr = fa; f_flush = fl; f_rsp_ready = frdy;
        l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_rsp_ready = lrdy;
        #1;
        check("f_rsp_valid", 32'(f_rsp_valid), 32'(pend && pend_f));
        check("l_rsp_valid", 32'(l_rsp_valid), 32'(pend && !pend_f));
        if (pend && pend_f) begin
            check("f_rsp_data", f_rsp_data, pend_data);
            check("f_rsp_err", 32'(f_rsp_err), 32'(pend_err));
        end
        if (pend && !pend_f) check("l_rsp_data", l_rsp_data, pend_data);
        free = !pend || (pend_f ? (frdy || fl) : lrdy);
        fe = fr && !fl;
        wl = free && lr && (!fe || ptr_l);
        wf = free && fe && !wl;
        check("f_gnt", 32'(f_gnt), 32'(wf));
        check("l_gnt", 32'(l_gnt), 32'(wl));
        if (wf) begin
            err = fa[1:0] != 2'b00 || fa > MEM_BYTES - 4;
            check("f mem_stall", 32'(mem_stall), 32'(err));
            check("f mem_we", 32'(mem_we), 0);
            if (!err) check("f mem_addr", mem_addr, fa);
            pend = 1; pend_f = 1; pend_err = err;
            pend_data = err ? 32'h0 : shadow[fa[16:2]];
        end else if (wl) begin
            ok = la <= MEM_BYTES - 4;
            check("l mem_we", 32'(mem_we), 32'(lw && ok));
            if (ok) begin
                check("l mem_addr", mem_addr, la);
                check("l mem_stall", 32'(mem_stall), 0);
            end
            if (lw && ok) check("l mem_wdata", mem_wdata, ld);
            pend = 1; pend_f = 0; pend_err = 0;
            pend_data = (lw || !ok) ? 32'h0 : shadow[la[16:2]];
            if (lw && ok) shadow[la[16:2]] = ld;
        end else begin
            check("idle mem_stall", 32'(mem_stall), 1);
            check("idle mem_we", 32'(mem_we), 0);
            if (free) pend = 0;
        end
`ifdef IMEM_ARB_RR_EN
        if (free && lr && fe) ptr_l = !wl;
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, 1, 0, 0, 0, 0, 1);
    endtask

    function automatic logic [31:0] rand_faddr();
        int r = $urandom_range(0, 19);
        return r < 16 ? 32'(r * 4) : r == 16 ? 32'h1FFFC : r == 17 ? 32'h20000 : r == 18 ? 32'h22 : 32'h1FFFD;
    endfunction

    function automatic logic [31:0] rand_laddr();
        int r = $urandom_range(0, 17);
        return r < 16 ? 32'(r * 4) : r == 16 ? 32'h1FFFC : 32'h20004;
    endfunction

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i]    = 32'(i) * 32'h01010101 ^ 32'hA5000000;
            shadow[i] = 32'(i) * 32'h01010101 ^ 32'hA5000000;
        end
        do_reset();
        // fetch stream
        step(1, 'h0, 0, 1, 0, 0, 0, 0, 1);
        step(1, 'h4, 0, 1, 0, 0, 0, 0, 1);
        step(1, 'h8, 0, 1, 0, 0, 0, 0, 1);
        idle();
        // back-pressure at 0x10
        step(1, 'h10, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 'h14, 0, 0, 0, 0, 0, 0, 1);
        step(1, 'h14, 0, 1, 0, 0, 0, 0, 1);
        idle();
        // contention
        for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 0, 1, 1, 0, 'h30, 0, 1);
        idle();
        // write then fetch
        step(0, 0, 0, 1, 1, 1, 'h20, 'hDEADBEEF, 1);
        step(1, 'h20, 0, 1, 0, 0, 0, 0, 1);
        idle();
        // errors and range boundary
        step(1, 'h22, 0, 1, 0, 0, 0, 0, 1);
        step(1, 'h20000, 0, 1, 0, 0, 0, 0, 1);
        step(1, 'h1FFFC, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 1, 'h20000, 'h12345678, 1);
        step(0, 0, 0, 1, 1, 0, 'h20000, 0, 1);
        idle();
        // flush on grant, flush while busy (with and without loader)
        step(1, 'h8, 1, 1, 0, 0, 0, 0, 1);
        step(1, 'h8, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 1);
        idle();
        step(1, 'hC, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 'h10, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 1);
        idle();
        // reset mid-access
        step(1, 'h4, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        idle();
        idle();
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bit fr   = $urandom_range(0, 9) < 6;
            bit fl   = $urandom_range(0, 9) == 0;
            bit frdy = $urandom_range(0, 9) < 7;
            bit lr   = $urandom_range(0, 9) < 4;
            bit lw   = $urandom_range(0, 1) == 1;
            bit lrdy = $urandom_range(0, 9) < 7;
            step(fr, rand_faddr(), fl, frdy, lr, lw, rand_laddr(), $urandom, lrdy);
            if (n == 1500) do_reset();
        end
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
